// File: rtl/modexp_seq.sv
// modexp_seq: packs a 32-bit input stream into 64-bit operand words for the
// modular-exponentiation core, launches it, and streams its result back out.
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   in_data/in_valid/in_ready   32-bit software word stream (header + operands)
//   out_data/out_valid/out_ready/out_last  32-bit result stream, lo half first
//   startInput, startCompute, getResult    one-cycle strobes to the core
//   m_buf..t_buf, nprime0_buf   operand words and n' bit 0 presented to the core
//   res_out, mx_done            core result word and completion level
//   busy                        high from header acceptance to last result word
module modexp_seq #(
    parameter int DATA_WIDTH = 64,
    parameter int NWORDS     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [31:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  startInput,
    output logic                  startCompute,
    output logic                  getResult,
    output logic [DATA_WIDTH-1:0] m_buf,
    output logic [DATA_WIDTH-1:0] e_buf,
    output logic [DATA_WIDTH-1:0] n_buf,
    output logic [DATA_WIDTH-1:0] r_buf,
    output logic [DATA_WIDTH-1:0] t_buf,
    output logic                  nprime0_buf,
    input  logic [DATA_WIDTH-1:0] res_out,
    input  logic                  mx_done,
    output logic                  busy
);

    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_COLLECT = 4'd1;
    localparam logic [3:0] S_PUSH    = 4'd2;
    localparam logic [3:0] S_LAUNCH  = 4'd3;
    localparam logic [3:0] S_WAIT    = 4'd4;
    localparam logic [3:0] S_FETCH   = 4'd5;
    localparam logic [3:0] S_CAPTURE = 4'd6;
    localparam logic [3:0] S_EMIT_LO = 4'd7;
    localparam logic [3:0] S_EMIT_HI = 4'd8;

    logic [3:0]            state;
    logic [IW-1:0]         idx;
    logic [2:0]            op;
    logic                  half;
    logic [DATA_WIDTH-1:0] res_q;

    logic in_hs;
    logic out_hs;
    logic is_last;

    assign in_hs   = in_valid && in_ready;
    assign out_hs  = out_valid && out_ready;
    assign is_last = (idx == LAST_IDX);

    // Replace one 32-bit half of an operand word, leaving the other intact.
    function automatic logic [DATA_WIDTH-1:0] put_half(
        input logic [DATA_WIDTH-1:0] cur,
        input logic                  hi,
        input logic [31:0]           w
    );
        put_half = cur;
        if (hi) put_half[DATA_WIDTH-1:32] = w;
        else    put_half[31:0]            = w;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            op          <= '0;
            half        <= 1'b0;
            res_q       <= '0;
            m_buf       <= '0;
            e_buf       <= '0;
            n_buf       <= '0;
            r_buf       <= '0;
            t_buf       <= '0;
            nprime0_buf <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_hs) begin
                        nprime0_buf <= in_data[0];
                        idx         <= '0;
                        op          <= '0;
                        half        <= 1'b0;
                        state       <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (in_hs) begin
                        case (op)
                            3'd0:    m_buf <= put_half(m_buf, half, in_data);
                            3'd1:    e_buf <= put_half(e_buf, half, in_data);
                            3'd2:    n_buf <= put_half(n_buf, half, in_data);
                            3'd3:    r_buf <= put_half(r_buf, half, in_data);
                            default: t_buf <= put_half(t_buf, half, in_data);
                        endcase
                        half <= ~half;
                        if (half) begin
                            // t.hi closes the index; counters rewind for the next one
                            if (op == 3'd4) begin
                                op    <= '0;
                                state <= S_PUSH;
                            end else begin
                                op <= op + 3'd1;
                            end
                        end
                    end
                end
                S_PUSH: begin
                    if (is_last) begin
                        state <= S_LAUNCH;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_COLLECT;
                    end
                end
                S_LAUNCH: begin
                    idx   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mx_done) state <= S_FETCH;
                end
                S_FETCH: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    // res_out is valid the cycle after getResult
                    res_q <= res_out;
                    state <= S_EMIT_LO;
                end
                S_EMIT_LO: begin
                    if (out_hs) state <= S_EMIT_HI;
                end
                S_EMIT_HI: begin
                    if (out_hs) begin
                        if (is_last) begin
                            state <= S_IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_FETCH;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready     = (state == S_IDLE) || (state == S_COLLECT);
    assign out_valid    = (state == S_EMIT_LO) || (state == S_EMIT_HI);
    assign out_data     = (state == S_EMIT_HI) ? res_q[DATA_WIDTH-1:32]
                                               : res_q[31:0];
    assign out_last     = (state == S_EMIT_HI) && is_last;
    assign startInput   = (state == S_PUSH);
    assign startCompute = (state == S_LAUNCH);
    assign getResult    = (state == S_FETCH);
    assign busy         = (state != S_IDLE);

endmodule

// File: tb/tb_modexp_seq.sv
// tb_modexp_seq: self-checking bench for modexp_seq with NWORDS=2 and NWORDS=1
// instances, a small core model, and a job-level reference model.
module tb_modexp_seq;

    localparam int NMAX  = 2;
    localparam int LIMIT = 2000;

    typedef struct {
        logic sel;       // 0: NWORDS=2 instance, 1: NWORDS=1 instance
        int   n;
        int   gap;       // idle cycles between input words
        int   bp;        // out_ready low cycles in first EMIT_HI
        logic early;     // mx_done high before launch
        logic directed;
        int   lat;       // header-to-launch cycles, -1 when not fixed
        int   wait_cyc;  // launch-to-first-getResult cycles
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset      = 1'b1;
    logic [31:0] in_data    = '0;
    logic        in_valid   = 1'b0;
    logic        out_ready  = 1'b1;
    logic        mx_done;
    logic [63:0] res_out    = '0;
    logic        sel        = 1'b0;
    logic        force_done = 1'b0;

    logic a_in_ready, a_out_valid, a_out_last, a_si, a_sc, a_gr, a_np0, a_busy;
    logic b_in_ready, b_out_valid, b_out_last, b_si, b_sc, b_gr, b_np0, b_busy;
    logic [31:0] a_out_data, b_out_data;
    logic [63:0] a_m, a_e, a_n, a_r, a_t;
    logic [63:0] b_m, b_e, b_n, b_r, b_t;

    modexp_seq #(.DATA_WIDTH(64), .NWORDS(2)) dut_a (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid && !sel), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_last(a_out_last),
        .startInput(a_si), .startCompute(a_sc), .getResult(a_gr),
        .m_buf(a_m), .e_buf(a_e), .n_buf(a_n), .r_buf(a_r), .t_buf(a_t),
        .nprime0_buf(a_np0), .res_out(res_out), .mx_done(mx_done), .busy(a_busy)
    );

    modexp_seq #(.DATA_WIDTH(64), .NWORDS(1)) dut_b (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid && sel), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_last(b_out_last),
        .startInput(b_si), .startCompute(b_sc), .getResult(b_gr),
        .m_buf(b_m), .e_buf(b_e), .n_buf(b_n), .r_buf(b_r), .t_buf(b_t),
        .nprime0_buf(b_np0), .res_out(res_out), .mx_done(mx_done), .busy(b_busy)
    );

    logic in_ready, out_valid, out_last, si, sc, gr, np0, busy;
    logic [31:0] out_data;
    logic [63:0] m, e, n, r, t;
    assign in_ready  = sel ? b_in_ready  : a_in_ready;
    assign out_valid = sel ? b_out_valid : a_out_valid;
    assign out_last  = sel ? b_out_last  : a_out_last;
    assign out_data  = sel ? b_out_data  : a_out_data;
    assign si        = sel ? b_si        : a_si;
    assign sc        = sel ? b_sc        : a_sc;
    assign gr        = sel ? b_gr        : a_gr;
    assign np0       = sel ? b_np0       : a_np0;
    assign busy      = sel ? b_busy      : a_busy;
    assign m         = sel ? b_m         : a_m;
    assign e         = sel ? b_e         : a_e;
    assign n         = sel ? b_n         : a_n;
    assign r         = sel ? b_r         : a_r;
    assign t         = sel ? b_t         : a_t;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Core model: completion 5 cycles after launch, result word per fetch.
    logic [63:0] res_vals [NMAX];
    int since     = -1000;
    int fetch_idx = 0;
    always @(posedge clk) begin
        if (reset)              since <= -1000;
        else if (sc)            since <= 0;
        else if (since >= 0)    since <= since + 1;
        if (sc) begin
            fetch_idx <= 0;
        end else if (gr) begin
            res_out   <= res_vals[fetch_idx % NMAX];
            fetch_idx <= fetch_idx + 1;
        end
    end
    assign mx_done = force_done || (since >= 4);

    // Reference expectations and monitor bookkeeping.
    logic [63:0] exp_op [NMAX][5];
    int   cur_n = 1;
    logic mon_on = 1'b0;
    int   cyc = 0;
    int   push_cnt, launch_cnt, get_cnt, out_cnt;
    int   hs_cyc, launch_cyc, first_get_cyc, first_out_cyc;
    logic held = 1'b0;
    logic [31:0] held_data;
    logic held_last;

    always begin
        int k;
        logic [31:0] ew;
        @(negedge clk);
        #1;
        cyc++;
        if (mon_on) begin
            if (si) begin
                chk("push_in_range", 64'(push_cnt < cur_n), 64'd1);
                if (push_cnt < cur_n) begin
                    chk("m_buf", m, exp_op[push_cnt][0]);
                    chk("e_buf", e, exp_op[push_cnt][1]);
                    chk("n_buf", n, exp_op[push_cnt][2]);
                    chk("r_buf", r, exp_op[push_cnt][3]);
                    chk("t_buf", t, exp_op[push_cnt][4]);
                end
                push_cnt++;
            end
            if (sc) begin
                launch_cnt++;
                launch_cyc = cyc;
            end
            if (gr) begin
                if (get_cnt == 0) first_get_cyc = cyc;
                get_cnt++;
            end
            if (si || sc || gr)
                chk("strobe_excl", 64'(int'(si) + int'(sc) + int'(gr)), 64'd1);
            if (in_valid && in_ready && !busy) hs_cyc = cyc;
            if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
            if (out_valid && held) begin
                chk("hold_data", 64'(out_data), 64'(held_data));
                chk("hold_last", 64'(out_last), 64'(held_last));
            end
            if (out_valid && out_ready) begin
                k = out_cnt;
                chk("out_in_range", 64'(k < 2 * cur_n), 64'd1);
                if (k < 2 * cur_n) begin
                    ew = (k % 2 == 1) ? res_vals[k / 2][63:32]
                                      : res_vals[k / 2][31:0];
                    chk("out_data", 64'(out_data), 64'(ew));
                    chk("out_last", 64'(out_last), 64'(k == 2 * cur_n - 1));
                end
                out_cnt++;
            end
            held      = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
        end
    end

    task automatic send(input logic [31:0] w, input int gap);
        int b = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && b < LIMIT) begin
            @(negedge clk);
            b++;
        end
        chk("send_timeout", 64'(b < LIMIT), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic run_job(input vec_t v);
        logic [31:0] w [0:10*NMAX];
        int b;
        int g0;
        sel        = v.sel;
        cur_n      = v.n;
        force_done = v.early;
        for (int k = 0; k <= 10 * v.n; k++) begin
            if (!v.directed)  w[k] = $urandom;
            else if (k == 0)  w[k] = 32'h1;
            else              w[k] = 32'(17 + 16 * ((k - 1) / 10) + (k - 1) % 10);
        end
        for (int i = 0; i < v.n; i++) begin
            for (int o = 0; o < 5; o++)
                exp_op[i][o] = {w[1 + i*10 + 2*o + 1], w[1 + i*10 + 2*o]};
            if (v.directed)
                res_vals[i] = (i == 0) ? 64'hAAAA_BBBB_CCCC_DDDD
                                       : 64'h0123_4567_89AB_CDEF;
            else
                res_vals[i] = {$urandom, $urandom};
        end
        push_cnt = 0; launch_cnt = 0; get_cnt = 0; out_cnt = 0;
        hs_cyc = -1; launch_cyc = -1; first_get_cyc = -1; first_out_cyc = -1;
        held   = 1'b0;
        mon_on = 1'b1;
        for (int k = 0; k <= 10 * v.n; k++) send(w[k], v.gap);
        if (v.bp > 0) begin
            b = 0;
            while (out_cnt < 1 && b < LIMIT) begin
                @(negedge clk);
                b++;
            end
            out_ready = 1'b0;
            g0 = get_cnt;
            repeat (v.bp) @(negedge clk);
            chk("stall_no_fetch", 64'(get_cnt), 64'(g0));
            chk("stall_valid", 64'(out_valid), 64'd1);
            out_ready = 1'b1;
        end
        b = 0;
        while ((out_cnt < 2 * v.n || busy) && b < LIMIT) begin
            @(negedge clk);
            b++;
        end
        chk("job_timeout", 64'(b < LIMIT), 64'd1);
        chk("push_total", 64'(push_cnt), 64'(v.n));
        chk("launch_total", 64'(launch_cnt), 64'd1);
        chk("fetch_total", 64'(get_cnt), 64'(v.n));
        chk("out_total", 64'(out_cnt), 64'(2 * v.n));
        chk("busy_after", 64'(busy), 64'd0);
        chk("in_ready_after", 64'(in_ready), 64'd1);
        chk("nprime0", 64'(np0), 64'(w[0][0]));
        if (v.lat >= 0)
            chk("launch_latency", 64'(launch_cyc - hs_cyc), 64'(v.lat));
        chk("wait_len", 64'(first_get_cyc - launch_cyc), 64'(v.wait_cyc));
        chk("result_path", 64'(first_out_cyc - first_get_cyc), 64'd2);
        mon_on     = 1'b0;
        force_done = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vec_t vt [7];
        vt[0] = '{1'b0, 2, 0, 0, 1'b0, 1'b1, 23, 6};
        vt[1] = '{1'b0, 2, 1, 0, 1'b0, 1'b1, -1, 6};
        vt[2] = '{1'b0, 2, 0, 7, 1'b0, 1'b0, 23, 6};
        vt[3] = '{1'b0, 2, 0, 0, 1'b1, 1'b0, 23, 2};
        vt[4] = '{1'b1, 1, 0, 0, 1'b0, 1'b0, 12, 6};
        vt[5] = '{1'b1, 1, 1, 3, 1'b1, 1'b0, -1, 2};
        vt[6] = '{1'b0, 2, 1, 7, 1'b0, 1'b0, -1, 6};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            chk("rst_in_ready", 64'(in_ready), 64'd1);
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_out_last", 64'(out_last), 64'd0);
            chk("rst_strobes", 64'({si, sc, gr}), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_bufs", m | e | n | r | t, 64'd0);
            chk("rst_np0", 64'(np0), 64'd0);
        end
        sel = 1'b0;

        for (int i = 0; i < 7; i++) run_job(vt[i]);

        // Reset in the middle of operand collection.
        sel = 1'b0;
        send(32'h1, 0);
        send(32'h5, 0);
        send(32'h6, 0);
        send(32'h7, 0);
        chk("mid_m_buf", m, 64'h0000_0006_0000_0005);
        chk("mid_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_bufs", m | e | n | r | t, 64'd0);
        chk("mid_rst_np0", 64'(np0), 64'd0);
        chk("mid_rst_strobes", 64'({si, sc, gr}), 64'd0);
        run_job(vt[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/modexp_seq.md
# modexp_seq

Operand/result sequencer sitting directly in front of and behind the modular-exponentiation core inside the multimedia-file-encryption datapath. It accepts a 32-bit word stream from the software side, packs it into DATA_WIDTH-bit operand words, and loads the core one word-index per `startInput` pulse. It then launches the computation, waits for completion, and unloads the result through `getResult`, re-emitting it as a 32-bit stream with valid/ready backpressure.

## Interface
- `DATA_WIDTH`, 64: core operand word width; must equal 64 (two 32-bit halves).
- `NWORDS`, 32: operand words per operand (2048-bit operands); ≥1; index counter is `$clog2(NWORDS)` bits, min 1.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `in_data` in 32: software word.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: sequencer accepts `in_data` this cycle.
- `out_data` out 32: result word.
- `out_valid` out 1: `out_data` valid.
- `out_ready` in 1: consumer accepts `out_data`.
- `out_last` out 1: high with the final result word.
- `startInput` out 1: one-cycle load strobe per word index.
- `startCompute` out 1: one-cycle compute launch.
- `getResult` out 1: one-cycle result fetch strobe.
- `m_buf`, `e_buf`, `n_buf`, `r_buf`, `t_buf` out DATA_WIDTH each: operand words, stable while `startInput` is high.
- `nprime0_buf` out 1: n' bit 0, from the header word.
- `res_out` in DATA_WIDTH: core result word, valid the cycle after `getResult`.
- `mx_done` in 1: core completion level.
- `busy` out 1: high from header acceptance until the last result word is accepted.

## Operation
- Input stream per job:
  - One header word; bit 0 → `nprime0_buf`, other bits ignored.
  - Then for index i = 0..NWORDS-1: ten words in the order m.lo, m.hi, e.lo, e.hi, n.lo, n.hi, r.lo, r.hi, t.lo, t.hi.
- Counters: `idx` (word index), `op` (0..4), `half` (0 = lo, 1 = hi). The lo half is written to bits [31:0] and the hi half to bits [63:32] of the selected `*_buf` register.
- States:
  - IDLE: `in_ready`=1. On handshake, capture `nprime0_buf`, clear counters, set `busy` → COLLECT.
  - COLLECT: `in_ready`=1. Each handshake advances half → op. When the handshake on t.hi occurs → PUSH.
  - PUSH: `startInput`=1 for one cycle, `in_ready`=0. If `idx`==NWORDS-1 → LAUNCH; else `idx`++, `op`=0, `half`=0 → COLLECT.
  - LAUNCH: `startCompute`=1 for one cycle, `idx`=0 → WAIT.
  - WAIT: hold until `mx_done`=1 → FETCH. If `mx_done` is already high on entry, leave after one cycle.
  - FETCH: `getResult`=1 for one cycle → CAPTURE.
  - CAPTURE: register `res_out` into `res_q` → EMIT_LO.
  - EMIT_LO: `out_valid`=1, `out_data`=`res_q[31:0]`. On handshake → EMIT_HI.
  - EMIT_HI: `out_valid`=1, `out_data`=`res_q[63:32]`, `out_last`=(`idx`==NWORDS-1). On handshake: if last, clear `busy` → IDLE; else `idx`++ → FETCH.
- Result words are unloaded in index order 0..NWORDS-1, lo half first.
- `in_ready` is 0 in every state other than IDLE and COLLECT. `out_valid` is 0 in every state other than EMIT_LO and EMIT_HI.
- `out_data` and `out_last` hold stable while `out_valid`=1 and `out_ready`=0.
- `*_buf` registers keep their last values after PUSH and are only overwritten by the next matching input half.

## Timing
- Reset values: state IDLE, all counters 0, all `*_buf`=0, `nprime0_buf`=0, `res_q`=0. `in_ready`=1 (IDLE) in the cycle after reset. `out_valid`, `out_last`, `startInput`, `startCompute`, `getResult`, `busy` = 0.
- `reset` asserted in any state, including mid-load or mid-WAIT, returns to IDLE on the next edge and drops every strobe that cycle. The core is reset by the same `reset`.
- Load latency: `startInput` is high in the cycle after the t.hi handshake. The next index's m.lo can be accepted one cycle after `startInput`.
- Minimum input-to-launch time: 1 + 11·NWORDS cycles from header handshake to `startCompute`.
- Result path: `getResult` at cycle k, `res_out` sampled at k+1, `out_valid` at k+2. Minimum 4 cycles per result index with `out_ready` held high.
- Strobes are mutually exclusive. Each strobe is high for exactly one cycle per occurrence.

## Test plan
- NWORDS=2, header 0x1, m.lo=0x11…t.hi=0x1A for idx0 (words 0x11..0x1A), `out_ready`=1, `mx_done` raised 5 cycles after `startCompute`, `res_out`=0xAAAA_BBBB_CCCC_DDDD → `startInput` twice with `m_buf`=0x12_0000_0011 for idx0, `nprime0_buf`=1, one `startCompute`, outputs 0xCCCCDDDD, 0xAAAABBBB, …, `out_last` on the 4th word, `busy` low afterwards.
- `in_valid` toggled every other cycle → `*_buf` contents are identical to the gap-free run; `startInput` count = NWORDS.
- `out_ready` low for 7 cycles in EMIT_HI → `out_data` held stable; no further `getResult` until the handshake.
- `mx_done` held high before LAUNCH → WAIT lasts one cycle, then FETCH.
- `reset` pulsed in COLLECT after 3 words → IDLE next cycle, all `*_buf`=0, `in_ready`=1, a fresh job completes normally.
- NWORDS=1 → `out_last` on the 2nd output word; `idx` never increments.
